mem_port_arbiter: RTL and testbench

//  Shares the single byte-wide memory port between the multicycle CPU datapath and a debug/loader port.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings and default widths for the CPU/debug memory port arbiter.
package mips_mem_pkg;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_WAIT = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ISSUE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DBG  = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous memory port between the CPU datapath and a debug/loader port.
// Optional anti-starvation guard for the debug port: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be at least 1");
  end

  logic [1:0]    state_q, state_d;
  grant_e        grant_q, grant_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          resp_we_q, resp_we_d;
  logic          cpu_wins, dbg_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int WCW = $clog2(MAX_WAIT + 1);
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  // dbg overrides CPU priority once it has watched MAX_WAIT CPU grants go by.
  assign dbg_wins = dbg_req && (!cpu_req || (wait_cnt_q == WCW'(MAX_WAIT)));
  assign cpu_wins = cpu_req && !dbg_wins;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!dbg_req || dbg_wins) begin
        wait_cnt_d = '0;
      end else if (cpu_wins && (wait_cnt_q != WCW'(MAX_WAIT))) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  assign dbg_wins = dbg_req && !cpu_req;
  assign cpu_wins = cpu_req;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_we_d   = resp_we_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = GNT_NONE;
        if (cpu_wins) begin
          grant_d     = GNT_CPU;
          state_d     = ST_ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          resp_we_d   = cpu_we;
        end else if (dbg_wins) begin
          grant_d     = GNT_DBG;
          state_d     = ST_ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          resp_we_d   = dbg_we;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // mem_* are cleared asynchronously so a reset aborts an access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_we_q   <= resp_we_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

  // Memory data arrives in RESP; writes return zero.
  assign cpu_ack   = (state_q == ST_RESP) && (grant_q == GNT_CPU);
  assign dbg_ack   = (state_q == ST_RESP) && (grant_q == GNT_DBG);
  assign cpu_rdata = (cpu_ack && !resp_we_q) ? mem_rdata : '0;
  assign dbg_rdata = (dbg_ack && !resp_we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (service order, fixed latency, byte-array memory contents).
module tb_mem_port_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, dbg_ack, mem_en, mem_we, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int both_ack_cnt = 0;
  int we_cycles    = 0;
  int cpu_ack_cnt  = 0;

  logic          fill_req;
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  logic [15:0]   exp_q[$];

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] fill_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : ((a * 8'd37) ^ 8'h5A);
  endfunction

  // synchronous memory: read data valid the cycle after mem_en
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill_val(8'(i));
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (cpu_ack && dbg_ack) both_ack_cnt++;
    if (mem_we) we_cycles++;
    if (cpu_ack) cpu_ack_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-port access: raise req, wait for ack (bounded), drop req, return to IDLE
  task automatic run_access(input bit use_cpu, input bit we, input logic [7:0] addr,
                            input logic [7:0] wdata, output logic [7:0] rdata, output int lat);
    rdata = 8'h00;
    lat   = -1;
    if (use_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      if (use_cpu && cpu_ack) begin rdata = cpu_rdata; lat = c; break; end
      if (!use_cpu && dbg_ack) begin rdata = dbg_rdata; lat = c; break; end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; fill_req = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = fill_val(8'(i));
    step();
    fill_req = 1'b0;
    cpu_req = 1'b1;
    step();
    n_checks++;
    if ({busy, mem_en, mem_we, cpu_ack, dbg_ack} !== 5'b0)
      $display("FAIL reset_ctrl: got busy/en/we/cack/dack=%b expected 00000",
               {busy, mem_en, mem_we, cpu_ack, dbg_ack});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== 32'h0)
      $display("FAIL reset_data: got %h expected 00000000", {mem_addr, mem_wdata, cpu_rdata, dbg_rdata});
    else n_pass++;
    cpu_req = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, cpu_ack} !== {1'b1, 1'b0, 8'h10, 1'b0})
      $display("FAIL cpu_read_issue: got en/we/addr/ack=%b/%b/%h/%b expected 1/0/10/0",
               mem_en, mem_we, mem_addr, cpu_ack);
    else n_pass++;
    cpu_addr = 8'h11;
    step();
    n_checks++;
    if ({cpu_ack, cpu_rdata, dbg_ack} !== {1'b1, ref_mem[8'h10], 1'b0})
      $display("FAIL cpu_read_ack: got ack/rdata/dack=%b/%h/%b expected 1/%h/0",
               cpu_ack, cpu_rdata, dbg_ack, ref_mem[8'h10]);
    else n_pass++;
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b0, 8'h10})
      $display("FAIL field_stability: got en/addr=%b/%h expected 0/10", mem_en, mem_addr);
    else n_pass++;
    cpu_req = 1'b0;
    step();
    n_checks++;
    if ({busy, cpu_ack, cpu_rdata} !== 10'h0)
      $display("FAIL cpu_read_done: got busy/ack/rdata=%b/%b/%h expected 0/0/00", busy, cpu_ack, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_dbg_write();
    logic [7:0] rd;
    int lat, w0, a0;
    w0 = we_cycles;
    run_access(1'b0, 1'b1, 8'h20, 8'h3C, rd, lat);
    ref_mem[8'h20] = 8'h3C;
    n_checks++;
    if (lat != 2 || rd !== 8'h00) $display("FAIL dbg_write_ack: got lat/rdata=%0d/%h expected 2/00", lat, rd);
    else n_pass++;
    n_checks++;
    if (we_cycles - w0 != 1) $display("FAIL dbg_write_we_cycles: got %0d expected 1", we_cycles - w0);
    else n_pass++;
    n_checks++;
    if (dbg_ack !== 1'b0) $display("FAIL dbg_ack_single: got %b expected 0", dbg_ack);
    else n_pass++;
    a0 = cpu_ack_cnt;
    run_access(1'b1, 1'b0, 8'h20, 8'h00, rd, lat);
    n_checks++;
    if (lat != 2 || rd !== ref_mem[8'h20] || cpu_ack_cnt - a0 != 1)
      $display("FAIL dbg_then_cpu_read: got lat/rdata/acks=%0d/%h/%0d expected 2/%h/1",
               lat, rd, cpu_ack_cnt - a0, ref_mem[8'h20]);
    else n_pass++;
  endtask

  task automatic test_collision();
    int cc, dc;
    logic [7:0] crd, drd;
    cc = -1; dc = -1; crd = '0; drd = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (cpu_ack) begin cc = c; crd = cpu_rdata; cpu_req = 1'b0; end
      if (dbg_ack) begin dc = c; drd = dbg_rdata; dbg_req = 1'b0; end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    n_checks++;
    if (cc != 2 || crd !== ref_mem[8'h10])
      $display("FAIL collision_cpu: got cycle/rdata=%0d/%h expected 2/%h", cc, crd, ref_mem[8'h10]);
    else n_pass++;
    n_checks++;
    if (dc != cc + 3 || drd !== ref_mem[8'h20])
      $display("FAIL collision_dbg: got cycle/rdata=%0d/%h expected %0d/%h", dc, drd, cc + 3, ref_mem[8'h20]);
    else n_pass++;
  endtask

  task automatic test_starvation();
    int n_acks, dbg_late, last_c;
    bit exp_dbg;
    n_acks = 0; dbg_late = 0; last_c = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
    for (int c = 1; c <= 40; c++) begin
      step();
      last_c = c;
      if (cpu_ack || dbg_ack) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_dbg = (n_acks == MAX_WAIT);
`else
        exp_dbg = 1'b0;
`endif
        n_checks++;
        if ({cpu_ack, dbg_ack} !== {!exp_dbg, exp_dbg} || c != 2 + 3 * n_acks ||
            (cpu_ack ? cpu_rdata : dbg_rdata) !== (exp_dbg ? ref_mem[8'h20] : ref_mem[8'h10]))
          $display("FAIL starvation_ack%0d: got cack/dack/cycle=%b/%b/%0d expected %b/%b/%0d",
                   n_acks, cpu_ack, dbg_ack, c, !exp_dbg, exp_dbg, 2 + 3 * n_acks);
        else n_pass++;
        if (dbg_ack) dbg_req = 1'b0;
        n_acks++;
        if (n_acks == 7) begin cpu_req = 1'b0; break; end
      end
    end
    n_checks++;
    if (n_acks != 7) $display("FAIL starvation_timeout: got %0d acks by cycle %0d expected 7", n_acks, last_c);
    else n_pass++;
    cpu_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (dbg_ack) begin dbg_late++; dbg_req = 1'b0; end
    end
    dbg_req = 1'b0;
    n_checks++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (dbg_late != 0) $display("FAIL starvation_drain: got %0d late dbg acks expected 0", dbg_late);
    else n_pass++;
`else
    if (dbg_late != 1) $display("FAIL starvation_drain: got %0d late dbg acks expected 1", dbg_late);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int a0, lat;
    logic [7:0] rd;
    a0 = cpu_ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    step();
    n_checks++;
    if ({mem_en, mem_we} !== 2'b11) $display("FAIL reset_mid_issue: got en/we=%b expected 11", {mem_en, mem_we});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_we, busy} !== 3'b000)
      $display("FAIL reset_mid_abort: got en/we/busy=%b expected 000", {mem_en, mem_we, busy});
    else n_pass++;
    cpu_req = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0 || cpu_ack_cnt != a0)
      $display("FAIL reset_mid_noack: got busy/acks=%b/%0d expected 0/0", busy, cpu_ack_cnt - a0);
    else n_pass++;
    run_access(1'b1, 1'b0, 8'h40, 8'h00, rd, lat);
    n_checks++;
    if (lat != 2 || rd !== ref_mem[8'h40])
      $display("FAIL reset_mid_recover: got lat/rdata=%0d/%h expected 2/%h", lat, rd, ref_mem[8'h40]);
    else n_pass++;
    run_access(1'b1, 1'b0, 8'h30, 8'h00, rd, lat);
    n_checks++;
    if (lat != 2 || rd !== ref_mem[8'h30])
      $display("FAIL reset_mid_no_write: got lat/rdata=%0d/%h expected 2/%h", lat, rd, ref_mem[8'h30]);
    else n_pass++;
  endtask

  // randomized rounds: service order, latency and data predicted at transaction level
  task automatic test_random();
    int mode;
    bit cwe, dwe;
    logic [7:0] ca, cw, da, dw, e;
    logic [15:0] got;
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      cwe = 1'($urandom_range(0, 1)); ca = 8'($urandom_range(0, 255)); cw = 8'($urandom_range(0, 255));
      dwe = 1'($urandom_range(0, 1)); da = 8'($urandom_range(0, 255)); dw = 8'($urandom_range(0, 255));
      if (r % 5 == 0) da = ca;
      exp_q.delete();
      if (mode != 1) begin
        e = cwe ? 8'h00 : ref_mem[ca];
        if (cwe) ref_mem[ca] = cw;
        exp_q.push_back({7'd2, 1'b0, e});
      end
      if (mode != 0) begin
        e = dwe ? 8'h00 : ref_mem[da];
        if (dwe) ref_mem[da] = dw;
        exp_q.push_back({(mode == 2) ? 7'd5 : 7'd2, 1'b1, e});
      end
      cpu_req = (mode != 1); cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
      dbg_req = (mode != 0); dbg_we = dwe; dbg_addr = da; dbg_wdata = dw;
      for (int c = 1; c <= 10; c++) begin
        step();
        if (cpu_ack || dbg_ack) begin
          got = cpu_ack ? {7'(c), 1'b0, cpu_rdata} : {7'(c), 1'b1, dbg_rdata};
          e = 8'h00;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL random_r%0d: got unexpected ack %h expected none", r, got);
          end else if (got !== exp_q[0]) begin
            $display("FAIL random_r%0d: got cycle/port/data=%h expected %h", r, got, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            n_pass++;
            void'(exp_q.pop_front());
          end
          if (cpu_ack) cpu_req = 1'b0;
          if (dbg_ack) dbg_req = 1'b0;
        end
        if (!cpu_req && !dbg_req) break;
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL random_r%0d_timeout: got %0d acks pending expected 0", r, exp_q.size());
      else n_pass++;
      cpu_req = 1'b0; dbg_req = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_collision();
    test_starvation();
    test_reset_mid();
    test_random();
    n_checks++;
    if (both_ack_cnt != 0) $display("FAIL both_acks: got %0d cycles expected 0", both_ack_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
